// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: steps one shared W-bit adder across WORDS slices (LSW first) to add N-bit operands.
// Optional build macro ADD_SEQ_SUB_EN adds a sub_i port that turns the operation into a - b.
module wide_add_sequencer #(
    parameter int W     = 32,
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WORDS*W-1:0]   a_i,
    input  logic [WORDS*W-1:0]   b_i,
    input  logic                 cin_i,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 sub_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WORDS*W-1:0]   sum_o,
    output logic                 cout_o,
    output logic                 ovf_o,
    output logic [W-1:0]         add_b1_o,
    output logic [W-1:0]         add_b2_o,
    output logic                 add_cin_o,
    input  logic [W-1:0]         add_q_i,
    input  logic                 add_cout_i
);
    localparam int N  = WORDS * W;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state: latch operands on start, then feed one slice per cycle with carry chained through carry_q.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        add_b1_o  = '0;
        add_b2_o  = '0;
        add_cin_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a_i;
`ifdef ADD_SEQ_SUB_EN
                    b_d     = sub_i ? ~b_i : b_i;
                    cin_d   = sub_i | cin_i;
`else
                    b_d     = b_i;
                    cin_d   = cin_i;
`endif
                end
            end
            RUN: begin
                add_b1_o  = a_q[int'(idx_q)*W +: W];
                add_b2_o  = b_q[int'(idx_q)*W +: W];
                add_cin_o = (idx_q == '0) ? cin_q : carry_q;
                sum_d[int'(idx_q)*W +: W] = add_q_i;
                carry_d   = add_cout_i;
                idx_d     = idx_q + 1'b1;
                if (idx_q == IW'(WORDS - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = add_cout_i;
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_q_i[W-1] != a_q[N-1]);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: scoreboard bench for wide_add_sequencer (W=32, WORDS=2) with a behavioural adder.
module tb_wide_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [63:0] a_i, b_i;
    logic        cin_i;
    logic        sub_v;
    logic        busy_o, done_o, cout_o, ovf_o;
    logic [63:0] sum_o;
    logic [31:0] add_b1_o, add_b2_o, add_q_i;
    logic        add_cin_o, add_cout_i;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        sq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] cur_a, cur_bb;
    logic        cur_ci, cur_c1;
    int          lat, bc;

    always #5 clk = ~clk;

    assign {add_cout_i, add_q_i} = {1'b0, add_b1_o} + {1'b0, add_b2_o} + 33'(add_cin_o);

    wide_add_sequencer #(.W(32), .WORDS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
`ifdef ADD_SEQ_SUB_EN
        .sub_i      (sub_v),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sum_o      (sum_o),
        .cout_o     (cout_o),
        .ovf_o      (ovf_o),
        .add_b1_o   (add_b1_o),
        .add_b2_o   (add_b2_o),
        .add_cin_o  (add_cin_o),
        .add_q_i    (add_q_i),
        .add_cout_i (add_cout_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        logic [64:0] full;
        logic [32:0] lo;
        exp_t        e;
        cur_a  = a;
        cur_bb = s ? ~b : b;
        cur_ci = s | c;
        full   = {1'b0, a} + {1'b0, cur_bb} + 65'(cur_ci);
        lo     = {1'b0, a[31:0]} + {1'b0, cur_bb[31:0]} + 33'(cur_ci);
        cur_c1 = lo[32];
        e.s = full[63:0];
        e.c = full[64];
        e.o = (a[63] == cur_bb[63]) && (full[63] != a[63]);
        sq.push_back(e);
    endtask

    task automatic wait_done(output int l, output int b);
        l = 1;
        b = 0;
        while (!done_o && l < 20) begin
            if (busy_o) begin
                check("add_b1", add_b1_o, cur_a[b*32 +: 32]);
                check("add_b2", add_b2_o, cur_bb[b*32 +: 32]);
                check("add_cin", add_cin_o, (b == 0) ? cur_ci : cur_c1);
                b++;
            end
            @(negedge clk);
            l++;
        end
        check("done_seen", done_o, 1);
        check("add_idle", {add_b1_o, add_b2_o} | 64'(add_cin_o), 0);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        push_exp(a, b, c, s);
        @(negedge clk);
        a_i = a; b_i = b; cin_i = c; sub_v = s; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(lat, bc);
    endtask

    // Scoreboard: each done pulse retires the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (sq.size() == 0) begin
                    check("unexpected_done", done_o, 0);
                end else begin
                    e = sq.pop_front();
                    check("sum", sum_o, e.s);
                    check("cout", cout_o, e.c);
                    check("ovf", ovf_o, e.o);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_v = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_cout_ovf", {cout_o, ovf_o}, 0);
        check("rst_add", {add_b1_o, add_b2_o} | 64'(add_cin_o), 0);
        rst_n = 1'b1;
        run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        check("latency", lat, 3);
        check("busy_cycles", bc, 2);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        check("busy_cycles2", bc, 2);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        push_exp(64'd3, 64'd4, 1'b0, 1'b0);
        @(negedge clk);
        a_i = 64'd3; b_i = 64'd4; cin_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        a_i = 64'd9; b_i = 64'd9;
        wait_done(lat, bc);
        @(negedge clk);
        start_i = 1'b0;
        check("start_ignored", busy_o, 0);
        check("held_sum", sum_o, 64'd7);
        run_op(64'd9, 64'd9, 1'b0, 1'b0);
        @(negedge clk);
        a_i = 64'd1; b_i = 64'd2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_sum", sum_o, 0);
        run_op(64'd10, 64'd20, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
`ifdef ADD_SEQ_SUB_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1);
        run_op(64'd7, 64'd5, 1'b0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
`endif
        repeat (4) @(negedge clk);
        check("sb_empty", 64'(sq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
